// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state type and default datapath width for the operand sequencer.
package calc_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // Key / ALU operation codes
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_SIGN = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  typedef enum logic [2:0] {
    StEnterA,
    StEnterB,
    StIssue,
    StWaitResult,
    StShowResult
  } state_t;

endpackage

// File: rtl/digit_accumulator.sv
// Decimal digit entry step: next_mag = mag*10 + digit, rejected above the magnitude limit.
module digit_accumulator #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MAX_MAG = 32767
) (
  input  logic [WIDTH-1:0] mag_i,
  input  logic [3:0]       digit_i,
  output logic [WIDTH-1:0] next_mag_o,
  output logic             reject_o
);

  // Wide enough that mag*10+9 never wraps, so the limit compare is exact.
  localparam int unsigned SumW = WIDTH + 4;

  logic [SumW-1:0] sum;

  // Combinational multiply-accumulate and limit check
  always_comb begin
    sum        = SumW'(mag_i) * SumW'(10) + SumW'(digit_i);
    reject_o   = (sum > SumW'(MAX_MAG));
    next_mag_o = sum[WIDTH-1:0];
  end

endmodule

// File: rtl/operand_sequencer.sv
// Builds two signed decimal operands from key events, sequences ALU requests and drives the display.
module operand_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MAX_MAG = 32767
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             key_valid_i,
  input  logic [3:0]       key_digit_i,
  input  logic [2:0]       key_op_i,
  input  logic             key_eq_i,
  output logic             key_read_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_op_o,
  output logic             alu_start_o,
  input  logic             alu_done_i,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_ovf_i,
  output logic [WIDTH-1:0] display_value_o,
  output logic             entry_err_o,
  output logic             calc_err_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic             b_digits_q, b_digits_d;
  logic [2:0]       op_q, op_d, pend_op_q, pend_op_d;
  logic             pend_valid_q, pend_valid_d;
  logic             consumed_q, consumed_d;
  logic             key_read_q, key_read_d, entry_err_q, entry_err_d, calc_err_q, calc_err_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, display_q, display_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             alu_start_q, alu_start_d;

  logic             accept, is_digit, is_sign, is_arith;
  logic [WIDTH-1:0] acc_in, acc_next, res_mag;
  logic             acc_reject, res_neg;

  // Sign-magnitude to two's complement; negative zero maps to zero naturally.
  function automatic logic [WIDTH-1:0] sm_val(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? (~mag + WIDTH'(1)) : mag;
  endfunction

  digit_accumulator #(
    .WIDTH  (WIDTH),
    .MAX_MAG(MAX_MAG)
  ) u_digit_accumulator (
    .mag_i     (acc_in),
    .digit_i   (key_digit_i),
    .next_mag_o(acc_next),
    .reject_o  (acc_reject)
  );

  // Key decode and acceptance; the accumulator works on whichever operand is being entered
  always_comb begin
    accept   = key_valid_i && !consumed_q &&
               (state_q inside {StEnterA, StEnterB, StShowResult});
    is_digit = !key_eq_i && (key_op_i == OP_NONE);
    is_sign  = !key_eq_i && (key_op_i == OP_SIGN);
    is_arith = !key_eq_i && (key_op_i inside {OP_ADD, OP_SUB, OP_MUL});
    acc_in   = (state_q == StEnterB) ? b_mag_q : a_mag_q;
    res_neg  = alu_result_i[WIDTH-1];
    res_mag  = res_neg ? (~alu_result_i + WIDTH'(1)) : alu_result_i;
  end

  // Next-state logic for the FSM, operands, handshakes and display
  always_comb begin
    state_d      = state_q;
    a_mag_d      = a_mag_q;
    a_neg_d      = a_neg_q;
    b_mag_d      = b_mag_q;
    b_neg_d      = b_neg_q;
    b_digits_d   = b_digits_q;
    op_d         = op_q;
    pend_op_d    = pend_op_q;
    pend_valid_d = pend_valid_q;
    calc_err_d   = calc_err_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    display_d    = display_q;
    consumed_d   = key_valid_i && (consumed_q || accept);
    key_read_d   = accept;
    entry_err_d  = 1'b0;
    alu_start_d  = 1'b0;

    if (accept) begin
      unique case (state_q)
        StEnterA: begin
          if (is_digit) begin
            calc_err_d = 1'b0;
            if (acc_reject) entry_err_d = 1'b1;
            else            a_mag_d     = acc_next;
          end else if (is_sign) begin
            a_neg_d    = !a_neg_q;
            calc_err_d = 1'b0;
          end else if (is_arith) begin
            op_d       = key_op_i;
            b_mag_d    = '0;
            b_neg_d    = 1'b0;
            b_digits_d = 1'b0;
            state_d    = StEnterB;
          end
        end
        StEnterB: begin
          if (is_digit) begin
            calc_err_d = 1'b0;
            b_digits_d = 1'b1;
            if (acc_reject) entry_err_d = 1'b1;
            else            b_mag_d     = acc_next;
          end else if (is_sign) begin
            b_neg_d    = !b_neg_q;
            calc_err_d = 1'b0;
          end else if (is_arith) begin
            if (b_digits_q) begin
              // Chained operator: compute the pending pair first, then continue with it
              pend_op_d    = key_op_i;
              pend_valid_d = 1'b1;
              state_d      = StIssue;
            end else begin
              op_d = key_op_i;
            end
          end else if (key_eq_i) begin
            if (!b_digits_q) begin
              b_mag_d = a_mag_q;
              b_neg_d = a_neg_q;
            end
            state_d = StIssue;
          end
        end
        StShowResult: begin
          if (is_digit) begin
            a_mag_d    = WIDTH'(key_digit_i);
            a_neg_d    = 1'b0;
            calc_err_d = 1'b0;
            state_d    = StEnterA;
          end else if (is_sign) begin
            a_neg_d    = !a_neg_q;
            calc_err_d = 1'b0;
          end else if (is_arith) begin
            op_d       = key_op_i;
            b_mag_d    = '0;
            b_neg_d    = 1'b0;
            b_digits_d = 1'b0;
            state_d    = StEnterB;
          end else if (key_eq_i) begin
            state_d = StIssue;
          end
        end
        default: ;
      endcase
    end

    if (state_q == StIssue) state_d = StWaitResult;

    if ((state_q == StWaitResult) && alu_done_i) begin
      a_mag_d    = res_mag;
      a_neg_d    = res_neg;
      calc_err_d = calc_err_q || alu_ovf_i;
      if (pend_valid_q) begin
        op_d         = pend_op_q;
        pend_valid_d = 1'b0;
        b_mag_d      = '0;
        b_neg_d      = 1'b0;
        b_digits_d   = 1'b0;
        state_d      = StEnterB;
      end else begin
        state_d = StShowResult;
      end
    end

    // Operands are captured on entry to ISSUE and stay put until the next request
    if ((state_d == StIssue) && (state_q != StIssue)) begin
      alu_a_d     = sm_val(a_mag_d, a_neg_d);
      alu_b_d     = sm_val(b_mag_d, b_neg_d);
      alu_op_d    = op_d;
      alu_start_d = 1'b1;
    end

    unique case (state_d)
      StEnterA, StShowResult: display_d = sm_val(a_mag_d, a_neg_d);
      StEnterB: display_d = b_digits_d ? sm_val(b_mag_d, b_neg_d) : sm_val(a_mag_d, a_neg_d);
      default:  display_d = display_q;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StEnterA;
      a_mag_q      <= '0;
      a_neg_q      <= 1'b0;
      b_mag_q      <= '0;
      b_neg_q      <= 1'b0;
      b_digits_q   <= 1'b0;
      op_q         <= OP_ADD;
      pend_op_q    <= OP_NONE;
      pend_valid_q <= 1'b0;
      consumed_q   <= 1'b0;
      key_read_q   <= 1'b0;
      entry_err_q  <= 1'b0;
      calc_err_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_NONE;
      alu_start_q  <= 1'b0;
      display_q    <= '0;
    end else begin
      state_q      <= state_d;
      a_mag_q      <= a_mag_d;
      a_neg_q      <= a_neg_d;
      b_mag_q      <= b_mag_d;
      b_neg_q      <= b_neg_d;
      b_digits_q   <= b_digits_d;
      op_q         <= op_d;
      pend_op_q    <= pend_op_d;
      pend_valid_q <= pend_valid_d;
      consumed_q   <= consumed_d;
      key_read_q   <= key_read_d;
      entry_err_q  <= entry_err_d;
      calc_err_q   <= calc_err_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
      display_q    <= display_d;
    end
  end

  assign key_read_o      = key_read_q;
  assign entry_err_o     = entry_err_q;
  assign calc_err_o      = calc_err_q;
  assign alu_a_o         = alu_a_q;
  assign alu_b_o         = alu_b_q;
  assign alu_op_o        = alu_op_q;
  assign alu_start_o     = alu_start_q;
  assign display_value_o = display_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed and random key sequences checked against a calculator-level reference model.
module tb_operand_sequencer;

  logic        clk = 1'b0;
  logic        nRST;
  logic        key_valid, key_eq, key_read;
  logic [3:0]  key_digit;
  logic [2:0]  key_op, alu_op;
  logic [15:0] alu_a, alu_b, alu_result, display_value;
  logic        alu_start, alu_done, alu_ovf, entry_err, calc_err;

  int n_checks = 0;
  int n_fail   = 0;

  operand_sequencer dut (
    .clk            (clk),
    .nRST           (nRST),
    .key_valid_i    (key_valid),
    .key_digit_i    (key_digit),
    .key_op_i       (key_op),
    .key_eq_i       (key_eq),
    .key_read_o     (key_read),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_op_o       (alu_op),
    .alu_start_o    (alu_start),
    .alu_done_i     (alu_done),
    .alu_result_i   (alu_result),
    .alu_ovf_i      (alu_ovf),
    .display_value_o(display_value),
    .entry_err_o    (entry_err),
    .calc_err_o     (calc_err)
  );

  always #5 clk = ~clk;

  // Reference model: calculator phase (0 first operand, 1 second operand, 2 result shown, 3 busy)
  int          m_phase, a_mag, b_mag;
  bit          a_neg, b_neg, b_dig, pend_v, m_cerr;
  logic [2:0]  m_op, m_pend, exp_opc;
  logic [15:0] m_disp, exp_a, exp_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sval(input int mag, input bit neg);
    int v;
    v = neg ? -mag : mag;
    return v[15:0];
  endfunction

  task automatic upd_disp();
    if (m_phase == 0 || m_phase == 2) m_disp = sval(a_mag, a_neg);
    else if (m_phase == 1)            m_disp = b_dig ? sval(b_mag, b_neg) : sval(a_mag, a_neg);
  endtask

  task automatic model_reset();
    m_phase = 0; a_mag = 0; b_mag = 0; a_neg = 0; b_neg = 0; b_dig = 0;
    m_op = 3'b010; m_pend = 3'b000; pend_v = 0; m_cerr = 0; m_disp = 16'h0;
  endtask

  task automatic model_key(input int d, input int op, input bit eq, output bit e_err,
                           output bit e_iss);
    bit dig, sgn, ari;
    dig = !eq && op == 0;
    sgn = !eq && op == 1;
    ari = !eq && (op >= 2 && op <= 4);
    e_err = 0;
    e_iss = 0;
    if (m_phase == 0) begin
      if (dig) begin
        m_cerr = 0;
        if (a_mag * 10 + d > 32767) e_err = 1; else a_mag = a_mag * 10 + d;
      end else if (sgn) begin a_neg = !a_neg; m_cerr = 0; end
      else if (ari) begin m_op = 3'(op); b_mag = 0; b_neg = 0; b_dig = 0; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (dig) begin
        m_cerr = 0; b_dig = 1;
        if (b_mag * 10 + d > 32767) e_err = 1; else b_mag = b_mag * 10 + d;
      end else if (sgn) begin b_neg = !b_neg; m_cerr = 0; end
      else if (ari) begin
        if (b_dig) begin m_pend = 3'(op); pend_v = 1; e_iss = 1; end
        else m_op = 3'(op);
      end else if (eq) begin
        if (!b_dig) begin b_mag = a_mag; b_neg = a_neg; end
        e_iss = 1;
      end
    end else if (m_phase == 2) begin
      if (dig) begin a_mag = d; a_neg = 0; m_cerr = 0; m_phase = 0; end
      else if (sgn) begin a_neg = !a_neg; m_cerr = 0; end
      else if (ari) begin m_op = 3'(op); b_mag = 0; b_neg = 0; b_dig = 0; m_phase = 1; end
      else if (eq) e_iss = 1;
    end
    if (e_iss) begin
      exp_a = sval(a_mag, a_neg); exp_b = sval(b_mag, b_neg); exp_opc = m_op; m_phase = 3;
    end
    upd_disp();
  endtask

  task automatic press(input int d, input int op, input bit eq, input int hold, output bit iss);
    bit e_err;
    int kr, st;
    model_key(d, op, eq, e_err, iss);
    @(negedge clk);
    key_valid = 1'b1; key_digit = 4'(d); key_op = 3'(op); key_eq = eq;
    kr = 0; st = 0;
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk); #1;
      kr += int'(key_read);
      st += int'(alu_start);
      if (i == 0) begin
        chk("key_read", key_read, 1);
        chk("entry_err", entry_err, e_err);
        chk("display", display_value, m_disp);
        chk("calc_err", calc_err, m_cerr);
        if (iss) begin
          chk("alu_a", alu_a, exp_a);
          chk("alu_b", alu_b, exp_b);
          chk("alu_op", alu_op, exp_opc);
        end
      end
    end
    @(negedge clk);
    key_valid = 1'b0; key_digit = 4'd0; key_op = 3'd0; key_eq = 1'b0;
    chk("key_read_count", kr, 1);
    chk("alu_start_count", st, int'(iss));
  endtask

  task automatic do_alu(input int lat);
    int av, bv, r, rs;
    bit ovf;
    logic [15:0] r16;
    av = int'($signed(exp_a));
    bv = int'($signed(exp_b));
    if (exp_opc == 3'b010)      r = av + bv;
    else if (exp_opc == 3'b011) r = av - bv;
    else                        r = av * bv;
    ovf = (r > 32767) || (r < -32768);
    r16 = r[15:0];
    repeat (lat) @(negedge clk);
    @(negedge clk);
    chk("alu_a_stable", alu_a, exp_a);
    chk("alu_b_stable", alu_b, exp_b);
    alu_done = 1'b1; alu_result = r16; alu_ovf = ovf;
    @(negedge clk);
    alu_done = 1'b0; alu_result = 16'h0; alu_ovf = 1'b0;
    rs = int'($signed(r16));
    a_neg = rs < 0;
    a_mag = (rs < 0) ? -rs : rs;
    m_cerr = m_cerr || ovf;
    if (pend_v) begin
      m_op = m_pend; pend_v = 0; b_mag = 0; b_neg = 0; b_dig = 0; m_phase = 1;
    end else begin
      m_phase = 2;
    end
    upd_disp();
    chk("result_display", display_value, m_disp);
    chk("result_calc_err", calc_err, m_cerr);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_key_read"}, key_read, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_alu_start"}, alu_start, 0);
    chk({tag, "_display"}, display_value, 0);
    chk({tag, "_entry_err"}, entry_err, 0);
    chk({tag, "_calc_err"}, calc_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b0;
    model_reset();
    #1 chk_zero("reset");
    @(negedge clk);
    nRST = 1'b1;
  endtask

  initial begin
    bit iss;
    int kind;
    nRST = 1'b0;
    key_valid = 0; key_digit = 0; key_op = 0; key_eq = 0;
    alu_done = 0; alu_result = 0; alu_ovf = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("por");
    nRST = 1'b1;

    // 12 + 34 =
    press(1, 0, 0, 0, iss); press(2, 0, 0, 0, iss); press(0, 2, 0, 0, iss);
    press(3, 0, 0, 0, iss); press(4, 0, 0, 0, iss); press(0, 0, 1, 0, iss);
    chk("add_issue", iss, 1);
    do_alu(2);
    chk("disp_46", display_value, 16'd46);
    // Re-issue from the result: 46 + 34
    press(0, 0, 1, 1, iss);
    do_alu(0);

    // Magnitude limit
    do_reset();
    press(3, 0, 0, 0, iss); press(2, 0, 0, 0, iss); press(7, 0, 0, 0, iss);
    press(6, 0, 0, 0, iss); press(7, 0, 0, 0, iss); press(8, 0, 0, 0, iss);
    chk("disp_limit", display_value, 16'd32767);

    // Sign toggle
    do_reset();
    press(5, 0, 0, 0, iss); press(0, 1, 0, 0, iss);
    chk("disp_neg5", display_value, 16'hFFFB);
    press(0, 1, 0, 0, iss);
    chk("disp_pos5", display_value, 16'd5);

    // Held key yields one event
    do_reset();
    press(4, 0, 0, 20, iss);
    press(4, 0, 0, 0, iss);
    chk("disp_44", display_value, 16'd44);

    // Chaining: 7 * 3 + 5 =
    do_reset();
    press(7, 0, 0, 0, iss); press(0, 4, 0, 0, iss); press(3, 0, 0, 0, iss);
    press(0, 2, 0, 2, iss);
    chk("chain_issue", iss, 1);
    do_alu(3);
    chk("disp_21", display_value, 16'd21);
    press(5, 0, 0, 0, iss); press(0, 0, 1, 0, iss);
    do_alu(1);
    chk("disp_26", display_value, 16'd26);

    // Reset while waiting for the ALU; late done must be ignored
    press(0, 0, 1, 0, iss);
    @(negedge clk);
    nRST = 1'b0;
    model_reset();
    #1 chk_zero("midop");
    @(negedge clk);
    nRST = 1'b1;
    alu_done = 1'b1; alu_result = 16'd123;
    @(negedge clk);
    alu_done = 1'b0; alu_result = 16'd0;
    @(negedge clk);
    chk_zero("late_done");
    press(9, 0, 0, 0, iss);
    chk("after_reset_disp", display_value, 16'd9);

    // Overflow: 300 * 200 = sets calc_err until the next digit
    do_reset();
    press(3, 0, 0, 0, iss); press(0, 0, 0, 0, iss); press(0, 0, 0, 0, iss);
    press(0, 4, 0, 0, iss); press(2, 0, 0, 0, iss); press(0, 0, 0, 0, iss);
    press(0, 0, 0, 0, iss); press(0, 0, 1, 0, iss);
    do_alu(0);
    chk("ovf_sticky", calc_err, 1);
    press(1, 0, 0, 0, iss);
    chk("ovf_cleared", calc_err, 0);

    // Random key streams
    do_reset();
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 11));
      if (kind <= 5) press(int'($urandom_range(0, 9)), 0, 0, int'($urandom_range(0, 3)), iss);
      else if (kind == 6) press(0, 1, 0, 0, iss);
      else if (kind <= 8) press(0, int'($urandom_range(2, 4)), 0, 0, iss);
      else if (kind == 9) press(0, 0, 1, int'($urandom_range(0, 2)), iss);
      else if (kind == 10) press(0, int'($urandom_range(5, 7)), 0, 0, iss);
      else begin
        // Stray done outside WAIT_RESULT
        iss = 0;
        @(negedge clk);
        alu_done = 1'b1; alu_result = 16'($urandom); alu_ovf = 1'b1;
        @(negedge clk);
        alu_done = 1'b0; alu_result = 16'h0; alu_ovf = 1'b0;
        chk("stray_done_disp", display_value, m_disp);
        chk("stray_done_cerr", calc_err, m_cerr);
      end
      if (iss) do_alu(int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
